// File: rtl/hier_icache_ctrl_pkg.sv
// Shared definitions for the queued hierarchical I-cache controller:
// register offsets (word index = add[4:2]), operation and FSM encodings, STATUS bit layout.
package hier_icache_ctrl_pkg;

  localparam logic [2:0] REG_ENABLE    = 3'd0;
  localparam logic [2:0] REG_FLUSH_L1  = 3'd1;
  localparam logic [2:0] REG_FLUSH_L2  = 3'd2;
  localparam logic [2:0] REG_SEL_FLUSH = 3'd3;
  localparam logic [2:0] REG_STATUS    = 3'd4;
  localparam logic [2:0] REG_BYPASS    = 3'd5;
  localparam logic [2:0] REG_PREFETCH  = 3'd6;

  localparam int STATUS_BUSY    = 0;
  localparam int STATUS_FULL    = 1;
  localparam int STATUS_TO_ERR  = 2;
  localparam int STATUS_CNT_LSB = 8;

  typedef enum logic [2:0] {
    OP_ENABLE,
    OP_DISABLE,
    OP_FLUSH_L1,
    OP_FLUSH_L2,
    OP_SEL_FLUSH,
    OP_BYPASS
  } op_e;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_e;

endpackage

// File: rtl/hier_icache_sf_fifo.sv
// Synchronous FIFO holding pending selective-flush addresses.
// Push and pop in the same cycle are both taken, even when full.
module hier_icache_sf_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/hier_icache_ctrl_seq.sv
// Peripheral-bus register file that sequences L1/L2 cache maintenance operations,
// with a selective-flush address FIFO, per-channel req/ack tracking and a watchdog.
module hier_icache_ctrl_seq
  import hier_icache_ctrl_pkg::*;
#(
  parameter int NB_CORES       = 8,
  parameter int NB_CACHE_BANKS = 4,
  parameter int ID_WIDTH       = 5,
  parameter int SF_FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      speriph_req_i,
  input  logic [31:0]               speriph_add_i,
  input  logic                      speriph_wen_i,
  input  logic [31:0]               speriph_wdata_i,
  input  logic [3:0]                speriph_be_i,
  input  logic [ID_WIDTH-1:0]       speriph_id_i,
  output logic                      speriph_gnt_o,
  output logic                      speriph_r_valid_o,
  output logic                      speriph_r_opc_o,
  output logic [ID_WIDTH-1:0]       speriph_r_id_o,
  output logic [31:0]               speriph_r_rdata_o,
  output logic [NB_CORES-1:0]       l1_bypass_req_o,
  input  logic [NB_CORES-1:0]       l1_bypass_ack_i,
  output logic [NB_CORES-1:0]       l1_flush_req_o,
  input  logic [NB_CORES-1:0]       l1_flush_ack_i,
  output logic [NB_CORES-1:0]       l1_sel_flush_req_o,
  input  logic [NB_CORES-1:0]       l1_sel_flush_ack_i,
  output logic [NB_CACHE_BANKS-1:0] l2_enable_req_o,
  input  logic [NB_CACHE_BANKS-1:0] l2_enable_ack_i,
  output logic [NB_CACHE_BANKS-1:0] l2_disable_req_o,
  input  logic [NB_CACHE_BANKS-1:0] l2_disable_ack_i,
  output logic [NB_CACHE_BANKS-1:0] l2_flush_req_o,
  input  logic [NB_CACHE_BANKS-1:0] l2_flush_ack_i,
  output logic [NB_CACHE_BANKS-1:0] l2_sel_flush_req_o,
  input  logic [NB_CACHE_BANKS-1:0] l2_sel_flush_ack_i,
  output logic [31:0]               sel_flush_addr_o,
  output logic [NB_CORES-1:0]       enable_l1_l15_prefetch_o,
  output logic                      done_evt_o
);

  localparam int CNT_W = $clog2(SF_FIFO_DEPTH) + 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  state_e                    state_q, state_d;
  op_e                       op_q, op_d;
  logic [NB_CORES-1:0]       l1_req_q, l1_req_d, l1_ack;
  logic [NB_CACHE_BANKS-1:0] l2_req_q, l2_req_d, l2_ack;
  logic [WD_W-1:0]           wd_q, wd_d;
  logic                      done_q, done_d, err_q, err_d, enabled_q, enabled_d;
  logic [NB_CORES-1:0]       bypass_q, bypass_d, bypass_tgt_q, bypass_tgt_d, prefetch_q, prefetch_d;
  logic [31:0]               sel_addr_q, sel_addr_d, rd_val, status_w, rdata_q, rdata_d;
  logic                      r_valid_q, r_opc_q, r_opc_d;
  logic [ID_WIDTH-1:0]       r_id_q, r_id_d;

  logic [2:0]       reg_sel;
  logic             is_wr, is_cmd_wr, is_sf_wr, cmd_acc, sf_push, fifo_pop;
  logic             fifo_full, fifo_empty;
  logic [31:0]      fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             unused_bits;

  assign unused_bits = ^{speriph_be_i, speriph_add_i, speriph_wdata_i};

  // Commands wait for an idle executor and an empty FIFO so they never overtake queued flushes.
  assign reg_sel   = speriph_add_i[4:2];
  assign is_wr     = ~speriph_wen_i;
  assign is_cmd_wr = is_wr & (reg_sel inside {REG_ENABLE, REG_FLUSH_L1, REG_FLUSH_L2, REG_BYPASS});
  assign is_sf_wr  = is_wr & (reg_sel == REG_SEL_FLUSH);
  assign speriph_gnt_o = speriph_req_i
                       & ~(is_cmd_wr & ~((state_q == ST_IDLE) & fifo_empty))
                       & ~(is_sf_wr & fifo_full);
  assign cmd_acc  = speriph_gnt_o & is_cmd_wr;
  assign sf_push  = speriph_gnt_o & is_sf_wr;
  assign fifo_pop = (state_q == ST_IDLE) & ~fifo_empty;

  hier_icache_sf_fifo #(.DEPTH(SF_FIFO_DEPTH), .WIDTH(32), .CNT_W(CNT_W)) u_sf_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (sf_push),
    .data_i  (speriph_wdata_i),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    l1_ack = '0;
    l2_ack = '0;
    case (op_q)
      OP_FLUSH_L1:  l1_ack = l1_flush_ack_i;
      OP_BYPASS:    l1_ack = l1_bypass_ack_i;
      OP_ENABLE:    l2_ack = l2_enable_ack_i;
      OP_DISABLE:   l2_ack = l2_disable_ack_i;
      OP_FLUSH_L2:  l2_ack = l2_flush_ack_i;
      OP_SEL_FLUSH: begin
        l1_ack = l1_sel_flush_ack_i;
        l2_ack = l2_sel_flush_ack_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    l1_req_d     = l1_req_q;
    l2_req_d     = l2_req_q;
    wd_d         = wd_q;
    done_d       = 1'b0;
    err_d        = err_q;
    enabled_d    = enabled_q;
    bypass_d     = bypass_q;
    bypass_tgt_d = bypass_tgt_q;
    sel_addr_d   = sel_addr_q;
    if (speriph_gnt_o & is_wr & (reg_sel == REG_STATUS) & speriph_wdata_i[STATUS_TO_ERR])
      err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        wd_d = '0;
        if (cmd_acc) begin
          case (reg_sel)
            REG_ENABLE: begin
              op_d     = speriph_wdata_i[0] ? OP_ENABLE : OP_DISABLE;
              l2_req_d = '1;
            end
            REG_FLUSH_L1: begin
              op_d     = OP_FLUSH_L1;
              l1_req_d = speriph_wdata_i[NB_CORES-1:0];
            end
            REG_FLUSH_L2: begin
              op_d     = OP_FLUSH_L2;
              l2_req_d = '1;
            end
            default: begin
              op_d         = OP_BYPASS;
              l1_req_d     = speriph_wdata_i[NB_CORES-1:0];
              bypass_tgt_d = bypass_q ^ speriph_wdata_i[NB_CORES-1:0];
            end
          endcase
          // An empty target mask has nobody to wait for: finish on the spot.
          if ((l1_req_d == '0) && (l2_req_d == '0)) done_d = 1'b1;
          else                                      state_d = ST_WAIT;
        end else if (fifo_pop) begin
          op_d       = OP_SEL_FLUSH;
          sel_addr_d = fifo_head;
          l1_req_d   = '1;
          l2_req_d   = '1;
          state_d    = ST_WAIT;
        end
      end
      default: begin
        wd_d     = wd_q + WD_W'(1);
        l1_req_d = l1_req_q & ~l1_ack;
        l2_req_d = l2_req_q & ~l2_ack;
        if ((l1_req_d == '0) && (l2_req_d == '0)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          if (op_q == OP_ENABLE)  enabled_d = 1'b1;
          if (op_q == OP_DISABLE) enabled_d = 1'b0;
          if (op_q == OP_BYPASS)  bypass_d  = bypass_tgt_q;
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          state_d  = ST_IDLE;
          done_d   = 1'b1;
          err_d    = 1'b1;
          l1_req_d = '0;
          l2_req_d = '0;
        end
      end
    endcase
  end

  always_comb begin
    status_w                 = '0;
    status_w[STATUS_BUSY]    = (state_q != ST_IDLE) | ~fifo_empty;
    status_w[STATUS_FULL]    = fifo_full;
    status_w[STATUS_TO_ERR]  = err_q;
    status_w[STATUS_CNT_LSB +: 8] = 8'(fifo_count);
    case (reg_sel)
      REG_ENABLE:    rd_val = {31'd0, enabled_q};
      REG_SEL_FLUSH: rd_val = 32'(fifo_count);
      REG_STATUS:    rd_val = status_w;
      REG_BYPASS:    rd_val = 32'(bypass_q);
      REG_PREFETCH:  rd_val = 32'(prefetch_q);
      default:       rd_val = '0;
    endcase
    prefetch_d = prefetch_q;
    if (speriph_gnt_o & is_wr & (reg_sel == REG_PREFETCH)) prefetch_d = speriph_wdata_i[NB_CORES-1:0];
    rdata_d = (speriph_gnt_o & speriph_wen_i) ? rd_val : '0;
    r_opc_d = speriph_gnt_o & (reg_sel == 3'd7);
    r_id_d  = speriph_gnt_o ? speriph_id_i : r_id_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_ENABLE;
      l1_req_q     <= '0;
      l2_req_q     <= '0;
      wd_q         <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      enabled_q    <= 1'b0;
      bypass_q     <= '0;
      bypass_tgt_q <= '0;
      prefetch_q   <= '0;
      sel_addr_q   <= '0;
      r_valid_q    <= 1'b0;
      r_opc_q      <= 1'b0;
      r_id_q       <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      l1_req_q     <= l1_req_d;
      l2_req_q     <= l2_req_d;
      wd_q         <= wd_d;
      done_q       <= done_d;
      err_q        <= err_d;
      enabled_q    <= enabled_d;
      bypass_q     <= bypass_d;
      bypass_tgt_q <= bypass_tgt_d;
      prefetch_q   <= prefetch_d;
      sel_addr_q   <= sel_addr_d;
      r_valid_q    <= speriph_gnt_o;
      r_opc_q      <= r_opc_d;
      r_id_q       <= r_id_d;
      rdata_q      <= rdata_d;
    end
  end

  assign l1_bypass_req_o          = (op_q == OP_BYPASS)    ? l1_req_q : '0;
  assign l1_flush_req_o           = (op_q == OP_FLUSH_L1)  ? l1_req_q : '0;
  assign l1_sel_flush_req_o       = (op_q == OP_SEL_FLUSH) ? l1_req_q : '0;
  assign l2_enable_req_o          = (op_q == OP_ENABLE)    ? l2_req_q : '0;
  assign l2_disable_req_o         = (op_q == OP_DISABLE)   ? l2_req_q : '0;
  assign l2_flush_req_o           = (op_q == OP_FLUSH_L2)  ? l2_req_q : '0;
  assign l2_sel_flush_req_o       = (op_q == OP_SEL_FLUSH) ? l2_req_q : '0;
  assign sel_flush_addr_o         = sel_addr_q;
  assign enable_l1_l15_prefetch_o = prefetch_q;
  assign done_evt_o               = done_q;
  assign speriph_r_valid_o        = r_valid_q;
  assign speriph_r_opc_o          = r_opc_q;
  assign speriph_r_id_o           = r_id_q;
  assign speriph_r_rdata_o        = rdata_q;

endmodule
